// File: rtl/sdram_slot_arb.sv
// ---------------------------------------------------------------------------
// sdram_slot_arb : round-robin slot arbiter for one port of the slotted SDRAM controller. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sdram_slot_arb #(
  parameter int NCLI   = 3,
  parameter int RD_LAT = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 slot_sync,
  input  logic [NCLI-1:0]      c_req,
  input  logic [2*NCLI-1:0]    c_we,
  input  logic [20*NCLI-1:0]   c_addr0,
  input  logic [20*NCLI-1:0]   c_addr1,
  input  logic [16*NCLI-1:0]   c_din,
  output logic [NCLI-1:0]      c_ack,
  output logic [NCLI-1:0]      c_rvalid,
  output logic [31:0]          c_rdata0,
  output logic [31:0]          c_rdata1,
  output logic [19:0]          mem_addr0,
  output logic [19:0]          mem_addr1,
  output logic [15:0]          mem_din,
  output logic [1:0]           mem_wr,
  output logic                 mem_rd,
  input  logic [31:0]          mem_dout0,
  input  logic [31:0]          mem_dout1,
  output logic                 busy
);

  localparam int IDW = (NCLI > 2) ? 2 : 1;

  logic [IDW-1:0]  r_ptr;
  logic [19:0]     r_mem_addr0;
  logic [19:0]     r_mem_addr1;
  logic [15:0]     r_mem_din;
  logic [1:0]      r_mem_wr;
  logic            r_mem_rd;
  logic [NCLI-1:0] r_ack;
  logic [NCLI-1:0] r_rvalid;
  logic [31:0]     r_rdata0;
  logic [31:0]     r_rdata1;

  logic [RD_LAT-1:0] r_tag_v;
  logic [IDW-1:0]    r_tag_id [RD_LAT];

  logic            w_any;
  logic [IDW-1:0]  w_win;
  logic [NCLI-1:0] w_ack;
  logic [19:0]     w_addr0;
  logic [19:0]     w_addr1;
  logic [15:0]     w_din;
  logic [1:0]      w_we;

  // Scan farthest-to-nearest from pointer+1 so the nearest requester overwrites.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int k = NCLI; k >= 1; k--) begin
      for (int j = 0; j < NCLI; j++) begin
        if (c_req[j] && (j == ((int'(r_ptr) + k) % NCLI))) begin
          w_any = 1'b1;
          w_win = IDW'(j);
        end
      end
    end
  end

  always_comb begin
    w_ack   = '0;
    w_addr0 = '0;
    w_addr1 = '0;
    w_din   = '0;
    w_we    = '0;
    for (int j = 0; j < NCLI; j++) begin
      if (w_win == IDW'(j)) begin
        w_ack[j] = w_any;
        w_addr0  = c_addr0[j*20 +: 20];
        w_addr1  = c_addr1[j*20 +: 20];
        w_din    = c_din[j*16 +: 16];
        w_we     = c_we[j*2 +: 2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr       <= IDW'(NCLI - 1);
      r_mem_addr0 <= '0;
      r_mem_addr1 <= '0;
      r_mem_din   <= '0;
      r_mem_wr    <= '0;
      r_mem_rd    <= 1'b0;
      r_ack       <= '0;
    end else begin
      r_ack <= '0;
      if (slot_sync) begin
        if (w_any) begin
          r_mem_addr0 <= w_addr0;
          r_mem_addr1 <= w_addr1;
          r_mem_din   <= w_din;
          r_mem_wr    <= w_we;
          r_mem_rd    <= ~|w_we;
          r_ack       <= w_ack;
          r_ptr       <= w_win;
        end else begin
          r_mem_wr <= '0;
          r_mem_rd <= 1'b0;
        end
      end
    end
  end

  // The held command always belongs to r_ptr: grants update both together.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tag_v <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        r_tag_id[i] <= '0;
      end
    end else begin
      r_tag_v[0]  <= slot_sync & r_mem_rd;
      r_tag_id[0] <= r_ptr;
      for (int i = 1; i < RD_LAT; i++) begin
        r_tag_v[i]  <= r_tag_v[i-1];
        r_tag_id[i] <= r_tag_id[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rvalid <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_rvalid <= '0;
      if (r_tag_v[RD_LAT-1]) begin
        r_rdata0 <= mem_dout0;
        r_rdata1 <= mem_dout1;
        for (int j = 0; j < NCLI; j++) begin
          r_rvalid[j] <= (r_tag_id[RD_LAT-1] == IDW'(j));
        end
      end
    end
  end

  assign mem_addr0 = r_mem_addr0;
  assign mem_addr1 = r_mem_addr1;
  assign mem_din   = r_mem_din;
  assign mem_wr    = r_mem_wr;
  assign mem_rd    = r_mem_rd;
  assign c_ack     = r_ack;
  assign c_rvalid  = r_rvalid;
  assign c_rdata0  = r_rdata0;
  assign c_rdata1  = r_rdata1;
  assign busy      = (slot_sync & r_mem_rd) | (|r_tag_v) | (|r_rvalid);

endmodule

`default_nettype wire

// File: tb/tb_sdram_slot_arb.sv
// ---------------------------------------------------------------------------
// tb_sdram_slot_arb : directed self-checking bench for sdram_slot_arb. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sdram_slot_arb;

  localparam int NCLI   = 3;
  localparam int RD_LAT = 12;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            slot_sync = 1'b0;
  logic [2:0]      c_req = '0;
  logic [5:0]      c_we = '0;
  logic [59:0]     c_addr0 = '0;
  logic [59:0]     c_addr1 = '0;
  logic [47:0]     c_din = '0;
  logic [2:0]      c_ack;
  logic [2:0]      c_rvalid;
  logic [31:0]     c_rdata0;
  logic [31:0]     c_rdata1;
  logic [19:0]     mem_addr0;
  logic [19:0]     mem_addr1;
  logic [15:0]     mem_din;
  logic [1:0]      mem_wr;
  logic            mem_rd;
  logic [31:0]     mem_dout0 = '0;
  logic [31:0]     mem_dout1 = '0;
  logic            busy;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  sdram_slot_arb #(.NCLI(NCLI), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset), .slot_sync(slot_sync),
    .c_req(c_req), .c_we(c_we), .c_addr0(c_addr0), .c_addr1(c_addr1), .c_din(c_din),
    .c_ack(c_ack), .c_rvalid(c_rvalid), .c_rdata0(c_rdata0), .c_rdata1(c_rdata1),
    .mem_addr0(mem_addr0), .mem_addr1(mem_addr1), .mem_din(mem_din),
    .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_dout0(mem_dout0), .mem_dout1(mem_dout1), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_client(input int c, input logic req, input logic [1:0] we,
                            input logic [19:0] a0, input logic [19:0] a1, input logic [15:0] d);
    c_req[c]          = req;
    c_we[c*2 +: 2]    = we;
    c_addr0[c*20 +: 20] = a0;
    c_addr1[c*20 +: 20] = a1;
    c_din[c*16 +: 16] = d;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    slot_sync = 1'b0;
    c_req     = '0;
    c_we      = '0;
    c_addr0   = '0;
    c_addr1   = '0;
    c_din     = '0;
    mem_dout0 = '0;
    mem_dout1 = '0;
    ticks(2);
    reset = 1'b0;
  endtask

  task automatic do_slot();
    slot_sync = 1'b1;
    tick();
    slot_sync = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ticks(2);
    n_total++; if (mem_addr0 !== 20'h0) $display("FAIL rst_addr0: got %h want 0", mem_addr0); else n_pass++;
    n_total++; if (mem_addr1 !== 20'h0) $display("FAIL rst_addr1: got %h want 0", mem_addr1); else n_pass++;
    n_total++; if (mem_din !== 16'h0) $display("FAIL rst_din: got %h want 0", mem_din); else n_pass++;
    n_total++; if (mem_wr !== 2'b00) $display("FAIL rst_wr: got %b want 00", mem_wr); else n_pass++;
    n_total++; if (mem_rd !== 1'b0) $display("FAIL rst_rd: got %b want 0", mem_rd); else n_pass++;
    n_total++; if (c_ack !== 3'b000) $display("FAIL rst_ack: got %b want 000", c_ack); else n_pass++;
    n_total++; if (c_rvalid !== 3'b000) $display("FAIL rst_rvalid: got %b want 000", c_rvalid); else n_pass++;
    n_total++; if (c_rdata0 !== 32'h0) $display("FAIL rst_rdata0: got %h want 0", c_rdata0); else n_pass++;
    n_total++; if (c_rdata1 !== 32'h0) $display("FAIL rst_rdata1: got %h want 0", c_rdata1); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [2:0]  exp_ack;
    logic [19:0] exp_addr;
    bit          bad;
    do_reset();
    for (int i = 0; i < 3; i++) set_client(i, 1'b1, 2'b00, 20'h100 + 20'(i), 20'h200 + 20'(i), 16'h0);
    for (int s = 0; s < 6; s++) begin
      exp_ack  = 3'b001 << (s % 3);
      exp_addr = 20'h100 + 20'(s % 3);
      do_slot();
      n_total++; if (c_ack !== exp_ack) $display("FAIL rr_ack_s%0d: got %b want %b", s, c_ack, exp_ack); else n_pass++;
      n_total++; if (mem_addr0 !== exp_addr) $display("FAIL rr_addr_s%0d: got %h want %h", s, mem_addr0, exp_addr); else n_pass++;
      bad = 1'b0;
      for (int c = 0; c < 15; c++) begin
        tick();
        if (c_ack !== 3'b000) bad = 1'b1;
      end
      n_total++; if (bad) $display("FAIL rr_quiet_s%0d: stray ack seen=1 want 0", s); else n_pass++;
    end
  endtask

  task automatic test_single_read();
    do_reset();
    set_client(1, 1'b1, 2'b00, 20'h00010, 20'h00011, 16'h0);
    do_slot();
    n_total++; if (c_ack !== 3'b010) $display("FAIL sr_ack: got %b want 010", c_ack); else n_pass++;
    n_total++; if (mem_rd !== 1'b1) $display("FAIL sr_rd: got %b want 1", mem_rd); else n_pass++;
    n_total++; if (mem_wr !== 2'b00) $display("FAIL sr_wr: got %b want 00", mem_wr); else n_pass++;
    n_total++; if (mem_addr0 !== 20'h00010) $display("FAIL sr_addr0: got %h want 00010", mem_addr0); else n_pass++;
    n_total++; if (mem_addr1 !== 20'h00011) $display("FAIL sr_addr1: got %h want 00011", mem_addr1); else n_pass++;
    c_req[1] = 1'b0;
    ticks(15);
    n_total++; if (mem_rd !== 1'b1) $display("FAIL sr_rd_held: got %b want 1", mem_rd); else n_pass++;
    slot_sync = 1'b1;
    #1;
    n_total++; if (busy !== 1'b1) $display("FAIL sr_busy_latch: got %b want 1", busy); else n_pass++;
    tick();
    slot_sync = 1'b0;
    n_total++; if (mem_rd !== 1'b0) $display("FAIL sr_rd_idle: got %b want 0", mem_rd); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL sr_busy_fly: got %b want 1", busy); else n_pass++;
    ticks(RD_LAT - 1);
    mem_dout0 = 32'hAAAA5555;
    mem_dout1 = 32'h12345678;
    n_total++; if (c_rvalid !== 3'b000) $display("FAIL sr_rvalid_early: got %b want 000", c_rvalid); else n_pass++;
    tick();
    n_total++; if (c_rvalid !== 3'b010) $display("FAIL sr_rvalid: got %b want 010", c_rvalid); else n_pass++;
    n_total++; if (c_rdata0 !== 32'hAAAA5555) $display("FAIL sr_rdata0: got %h want AAAA5555", c_rdata0); else n_pass++;
    n_total++; if (c_rdata1 !== 32'h12345678) $display("FAIL sr_rdata1: got %h want 12345678", c_rdata1); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL sr_busy_last: got %b want 1", busy); else n_pass++;
    mem_dout0 = 32'hDEADBEEF;
    tick();
    n_total++; if (c_rvalid !== 3'b000) $display("FAIL sr_rvalid_pulse: got %b want 000", c_rvalid); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL sr_busy_end: got %b want 0", busy); else n_pass++;
    n_total++; if (c_rdata0 !== 32'hAAAA5555) $display("FAIL sr_rdata_hold: got %h want AAAA5555", c_rdata0); else n_pass++;
  endtask

  task automatic test_write();
    bit bad;
    do_reset();
    set_client(2, 1'b1, 2'b01, 20'h80004, 20'h0, 16'h00FF);
    do_slot();
    n_total++; if (c_ack !== 3'b100) $display("FAIL wr_ack: got %b want 100", c_ack); else n_pass++;
    n_total++; if (mem_wr !== 2'b01) $display("FAIL wr_wr: got %b want 01", mem_wr); else n_pass++;
    n_total++; if (mem_rd !== 1'b0) $display("FAIL wr_rd: got %b want 0", mem_rd); else n_pass++;
    n_total++; if (mem_addr0 !== 20'h80004) $display("FAIL wr_addr0: got %h want 80004", mem_addr0); else n_pass++;
    n_total++; if (mem_din !== 16'h00FF) $display("FAIL wr_din: got %h want 00FF", mem_din); else n_pass++;
    c_req[2] = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (mem_wr !== 2'b01 || mem_addr0 !== 20'h80004 || mem_din !== 16'h00FF) bad = 1'b1;
    end
    n_total++; if (bad) $display("FAIL wr_hold: changed=1 want 0"); else n_pass++;
    do_slot();
    n_total++; if (mem_wr !== 2'b00) $display("FAIL wr_idle_after: got %b want 00", mem_wr); else n_pass++;
    bad = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (c_rvalid !== 3'b000 || busy !== 1'b0) bad = 1'b1;
      tick();
    end
    n_total++; if (bad) $display("FAIL wr_no_rvalid: rvalid_or_busy=1 want 0"); else n_pass++;
  endtask

  task automatic test_idle_slot();
    do_reset();
    set_client(0, 1'b1, 2'b00, 20'h00300, 20'h00301, 16'h0);
    do_slot();
    n_total++; if (c_ack !== 3'b001) $display("FAIL idle_first_ack: got %b want 001", c_ack); else n_pass++;
    c_req = '0;
    ticks(15);
    do_slot();
    n_total++; if (mem_wr !== 2'b00) $display("FAIL idle_wr: got %b want 00", mem_wr); else n_pass++;
    n_total++; if (mem_rd !== 1'b0) $display("FAIL idle_rd: got %b want 0", mem_rd); else n_pass++;
    n_total++; if (c_ack !== 3'b000) $display("FAIL idle_ack: got %b want 000", c_ack); else n_pass++;
    ticks(15);
    c_req = 3'b101;
    do_slot();
    n_total++; if (c_ack !== 3'b100) $display("FAIL idle_ptr_kept: got %b want 100", c_ack); else n_pass++;
  endtask

  task automatic test_late_request();
    bit bad;
    do_reset();
    do_slot();
    set_client(1, 1'b1, 2'b00, 20'h00400, 20'h00401, 16'h0);
    bad = 1'b0;
    for (int c = 0; c < 15; c++) begin
      if (c_ack !== 3'b000) bad = 1'b1;
      tick();
    end
    n_total++; if (bad) $display("FAIL late_no_ack: ack_seen=1 want 0"); else n_pass++;
    do_slot();
    n_total++; if (c_ack !== 3'b010) $display("FAIL late_ack: got %b want 010", c_ack); else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    bit bad;
    do_reset();
    set_client(1, 1'b1, 2'b00, 20'h00020, 20'h00021, 16'h0);
    do_slot();
    n_total++; if (c_ack !== 3'b010) $display("FAIL rmr_ack: got %b want 010", c_ack); else n_pass++;
    c_req = '0;
    ticks(15);
    do_slot();
    n_total++; if (busy !== 1'b1) $display("FAIL rmr_busy_fly: got %b want 1", busy); else n_pass++;
    ticks(4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_total++; if (busy !== 1'b0) $display("FAIL rmr_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (c_rvalid !== 3'b000) $display("FAIL rmr_rvalid: got %b want 000", c_rvalid); else n_pass++;
    bad = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (c_rvalid !== 3'b000 || busy !== 1'b0) bad = 1'b1;
    end
    n_total++; if (bad) $display("FAIL rmr_quiet: rvalid_or_busy=1 want 0"); else n_pass++;
    c_req = 3'b111;
    do_slot();
    n_total++; if (c_ack !== 3'b001) $display("FAIL rmr_ptr: got %b want 001", c_ack); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_read();
    test_write();
    test_idle_slot();
    test_late_request();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sdram_slot_arb.md
Name: sdram_slot_arb

Overview:
- Round-robin arbiter that shares one port (a or b) of the dual-port slotted SDRAM controller between NCLI requesters.
- The SDRAM controller latches port inputs once per 16-cycle slot and returns two 32-bit read words at a fixed latency.
- This block collects client requests, grants one per slot and holds the port command stable for a full slot.
- It routes the returned read data back to the granted client, tagged with a valid pulse.

Parameters:
- NCLI, 3: number of requesters, 2..4.
- RD_LAT, 12: cycles from the controller's latch strobe to read data valid on mem_dout0/1. Legal range 2..15.

Ports:
- clk  in  1  system clock, same as SDRAM controller.
- reset  in  1  synchronous, active-high.
- slot_sync  in  1  one-cycle pulse, high in the cycle the controller latches port inputs (its st_num==15).
- c_req  in  NCLI  per-client request level; held until c_ack.
- c_we  in  2*NCLI  per-client byte write enables; 0 = read.
- c_addr0  in  20*NCLI  per-client word address [20:1]; bit 20 selects the write bank.
- c_addr1  in  20*NCLI  per-client second read address, bank 1.
- c_din  in  16*NCLI  per-client write data.
- c_ack  out  NCLI  one-cycle grant pulse per client.
- c_rvalid  out  NCLI  one-cycle read-data-valid pulse per client.
- c_rdata0  out  32  read data for addr0, shared by all clients, qualified by c_rvalid.
- c_rdata1  out  32  read data for addr1, shared by all clients, qualified by c_rvalid.
- mem_addr0, mem_addr1  out  20  to controller addr_x0/addr_x1.
- mem_din  out  16  to controller din_x.
- mem_wr  out  2  to controller wr_x.
- mem_rd  out  1  to controller rd_x.
- mem_dout0, mem_dout1  in  32  from controller dout_x0/dout_x1.
- busy  out  1  high while a read is in flight.

Behaviour:
- Reset values:
  - mem_* = 0, c_ack = 0, c_rvalid = 0, c_rdata0/1 = 0, busy = 0.
  - Round-robin pointer = NCLI-1, so client 0 wins first.
  - Tag pipeline cleared.
  - Reset takes priority over every other event.
- Grant, evaluated only on slot_sync cycles:
  - Winner = first asserted c_req scanning from pointer+1 upward, modulo NCLI.
  - On the next edge: mem_* load the winner's fields, mem_rd = ~|c_we[winner], c_ack[winner] pulses for 1 cycle, pointer = winner.
  - No request: mem_wr = 0 and mem_rd = 0, which makes the slot an idle/refresh slot; pointer unchanged.
- Hold: mem_* are held constant between slot_sync pulses.
  - The controller latches them at the following slot_sync, so issue-to-latch is exactly one slot (16 cycles).
  - Clients may drop or change c_req/fields the cycle after c_ack.
- Tag pipeline:
  - When a slot_sync latches an mem_rd=1 command, the tag {valid, client id} enters a delay line of RD_LAT stages.
  - That latch is the slot_sync after the grant.
  - At the stage RD_LAT exit: c_rdata0/1 <= mem_dout0/1 and c_rvalid[id] pulses.
  - c_rvalid therefore rises RD_LAT+1 cycles after the latching slot_sync.
  - Write slots enter no tag. No c_rvalid is ever issued for a write.
- busy = 1 from the latching slot_sync until the c_rvalid cycle, inclusive.
- Boundaries:
  - A request arriving in the slot_sync cycle itself is eligible.
  - c_req deasserted on slot_sync is not granted.
  - c_we nonzero: the write wins over a read, so mem_rd = 0 (matches the controller's rd&~|wr gating).
  - Consecutive grants to different clients in back-to-back slots are allowed. With RD_LAT<16 at most one tag is live, but the delay line must not assume it.
  - slot_sync asserted in consecutive cycles (misconfiguration): each pulse is treated as a slot. Behaviour is defined but not required to be useful.
  - Reset mid-read: the tag is discarded and no c_rvalid is issued.

Test Plan:
- Single read: client 1 req, c_we=0, addr0=0x00010, addr1=0x00011, slot_sync@t0 → c_ack[1]@t0+1; mem_rd=1 latched @t0+16; mem_dout0/1=0xAAAA5555/0x12345678 presented at the exit cycle → c_rvalid[1]@t0+16+RD_LAT+1 with those values.
- Round-robin: clients 0,1,2 all req continuously over 6 slots → ack order 0,1,2,0,1,2, one per slot, never two acks in one cycle.
- Write: client 2 c_we=2'b01, addr0=0x80004, din=0x00FF → mem_wr=01, mem_rd=0, mem_addr0=0x80004 held 16 cycles; no c_rvalid ever.
- Idle slot: no c_req at slot_sync → mem_wr=0, mem_rd=0, pointer unchanged; next single request from client 2 is granted immediately.
- Late request: c_req rises the cycle after slot_sync → no ack until the next slot_sync, 16 cycles later.
- Reset mid-read: reset asserted 5 cycles after the latching slot_sync → busy=0 and c_rvalid=0 afterwards; pointer reset so client 0 wins next.
